pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Generic, parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one opaque payload vector between two pipeline stages using a valid/ready handshake.
- Includes a 2-entry skid buffer, so stalls propagate backwards with a registered `in_ready` while sustaining one beat per cycle.
- Provides a flush that kills held and incoming beats. Stage-specific control and data fields are packed into `in_data` by the instantiating stage.

Parameters:
- DATA_W, 160, payload width in bits (minimum 1).
- CLEAR_ON_FLUSH, 1, 1 = payload registers zeroed on flush; 0 = payload left unchanged, only valid flags cleared.
- RESET_VAL, {DATA_W{1'b0}}, payload value loaded at reset and, when CLEAR_ON_FLUSH = 1, on flush.

Ports:
- clk  input  1  pipeline clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- flush  input  1  synchronous kill of all held beats and of the beat offered this cycle.
- in_valid  input  1  upstream stage offers a beat.
- in_ready  output  1  registered; block can accept a beat this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  registered; out_data holds a valid beat.
- out_ready  input  1  downstream stage consumes the beat this cycle.
- out_data  output  DATA_W  registered payload to downstream stage.

Behaviour:
- Handshake definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - out_data and out_valid must not change while out_valid = 1 and out_ready = 0.
- Storage:
  - main register drives out_data and out_valid.
  - skid register holds skid_data and skid_valid.
  - in_ready is the registered value of !skid_valid.
- States:
  - EMPTY: out_valid = 0, skid_valid = 0.
  - BUSY: out_valid = 1, skid_valid = 0.
  - FULL: out_valid = 1, skid_valid = 1.
- Transitions when flush = 0:
  - EMPTY: in_fire → main ← in_data → BUSY. Otherwise stay in EMPTY.
  - BUSY, out_fire & in_fire: main ← in_data, stay in BUSY.
  - BUSY, out_fire & !in_fire: → EMPTY.
  - BUSY, !out_fire & in_fire: skid ← in_data → FULL.
  - BUSY, neither: hold.
  - FULL: in_ready = 0, so no in_fire is possible. out_fire → main ← skid_data → BUSY. Otherwise hold.
- Latency:
  - 1 cycle from in_fire to out_valid when in EMPTY or BUSY.
  - Throughput is 1 beat/cycle while out_ready = 1.
- Flush, highest priority:
  - Next state is EMPTY.
  - out_valid ← 0, skid_valid ← 0, in_ready ← 1.
  - The beat offered in the same cycle is discarded, even if in_fire.
  - If CLEAR_ON_FLUSH = 1, out_data and skid_data ← RESET_VAL.
  - flush together with out_fire: the beat counts as consumed downstream; the state is still EMPTY.
- Reset (rst = 0, asynchronous):
  - out_valid = 0, skid_valid = 0, in_ready = 1.
  - out_data = RESET_VAL, skid_data = RESET_VAL.
  - Reset asserted mid-transfer drops all beats.
  - Deassertion is synchronised externally; the first edge after deassertion may accept a beat.
- No beat is duplicated, dropped (except by flush or reset), or reordered.

Optional Feature:
- Macro: PIPE_STAGE_REG_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cnt, 32 bits.
  - Increments each cycle with out_valid = 1 and out_ready = 0.
  - Saturates at 32'hFFFFFFFF.
  - Cleared only by reset; unaffected by flush.
- When not defined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - state enum: PS_EMPTY, PS_BUSY, PS_FULL.
  - DEFAULT_DATA_W constant.
  - per-stage payload width constants: IF_ID_W, ID_EX_W, EX_MEM_W, MEM_WB_W.
- One natural sub-module: pipe_data_reg.
  - DATA_W-wide enable/clear register with asynchronous active-low reset to RESET_VAL.
  - Instantiated twice, once for main and once for skid.

Test Plan:
- Reset: hold rst = 0, then release; check out_valid = 0, in_ready = 1, out_data = 0. Drive in_valid = 1, in_data = 0xA5 with out_ready = 1; next cycle out_valid = 1, out_data = 0xA5.
- Streaming: 8 beats 0x01..0x08 back-to-back with out_ready held at 1; outputs appear 0x01..0x08 on consecutive cycles starting 1 cycle later; in_ready stays 1.
- Backpressure:
  - Send 0x11, 0x22, 0x33 with out_ready = 0 from cycle 1.
  - 0x11 is held on out_data; 0x22 goes to skid; in_ready = 0 next cycle; 0x33 is held upstream.
  - Raise out_ready: 0x11, 0x22, 0x33 delivered in order, none lost.
- Flush in FULL with in_valid = 1 carrying 0x44: next cycle out_valid = 0, in_ready = 1, out_data = 0 (CLEAR_ON_FLUSH = 1); 0x44 never appears.
- Asynchronous reset: pull rst low between clock edges while in FULL; out_valid drops to 0 immediately without a clock edge; in_ready = 1.
- With the macro defined: hold out_valid = 1 and out_ready = 0 for 5 cycles, then 1 cycle of ready; stall_cnt = 5. A flush leaves stall_cnt at 5.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the generic inter-stage pipeline register.
// Holds the occupancy state names, the default payload width and the
// per-stage payload widths that each stage packs into in_data.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_BUSY  = 2'd1,
    PS_FULL  = 2'd2
  } ps_state_e;

  localparam int DEFAULT_DATA_W = 160;

  localparam int IF_ID_W  = 64;
  localparam int ID_EX_W  = 160;
  localparam int EX_MEM_W = 112;
  localparam int MEM_WB_W = 72;

endpackage

// File: rtl/pipe_data_reg.sv
// DATA_W-wide payload register with load enable and synchronous clear.
// Clear wins over enable; both load RESET_VAL / d on the rising edge.
// Asynchronous active-low reset forces RESET_VAL.
module pipe_data_reg #(
  parameter int              DATA_W    = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Payload storage: reset/clear to RESET_VAL, otherwise load when enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RESET_VAL;
    end else if (clr) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with a 2-entry skid buffer.
// The main register drives out_data/out_valid; the skid register catches
// the one beat accepted while downstream stalls, so in_ready can be a
// registered signal without losing throughput.
// Optional: define PIPE_STAGE_REG_STALL_CNT_EN to add a saturating 32-bit
// stall_cnt output counting cycles with out_valid=1 and out_ready=0.
//
// Handshake: a beat moves on an interface when valid & ready are both 1 at
// a rising edge. Once out_valid is 1 it stays 1 with out_data stable until
// out_ready is seen; in_valid/in_data may be offered at any time and are
// taken only when in_ready is 1.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W         = DEFAULT_DATA_W,
  parameter int                CLEAR_ON_FLUSH = 1,
  parameter logic [DATA_W-1:0] RESET_VAL      = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;

  logic              in_fire;
  logic              out_fire;
  logic              main_en;
  logic              main_from_skid;
  logic              skid_en;
  logic              data_clr;
  logic              out_valid_n;
  logic              skid_valid_n;
  logic [DATA_W-1:0] main_d;

  // Occupancy state, decoded from the two valid flags; kept for debug/checkers.
  ps_state_e state_dbg;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign data_clr = flush & (CLEAR_ON_FLUSH != 0);
  assign main_d   = main_from_skid ? skid_data : in_data;

  // Decode occupancy from the valid flags.
  always_comb begin
    state_dbg = PS_EMPTY;
    if (skid_valid) begin
      state_dbg = PS_FULL;
    end else if (out_valid) begin
      state_dbg = PS_BUSY;
    end
  end

  // Next-state and register-enable decisions; flush overrides everything.
  always_comb begin
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    out_valid_n    = out_valid;
    skid_valid_n   = skid_valid;
    if (flush) begin
      out_valid_n  = 1'b0;
      skid_valid_n = 1'b0;
    end else begin
      case (state_dbg)
        PS_EMPTY: begin
          if (in_fire) begin
            main_en     = 1'b1;
            out_valid_n = 1'b1;
          end
        end
        PS_BUSY: begin
          if (out_fire && in_fire) begin
            main_en = 1'b1;
          end else if (out_fire) begin
            out_valid_n = 1'b0;
          end else if (in_fire) begin
            skid_en      = 1'b1;
            skid_valid_n = 1'b1;
          end
        end
        PS_FULL: begin
          // in_ready is low here, so only the drain of the main beat matters.
          if (out_fire) begin
            main_en        = 1'b1;
            main_from_skid = 1'b1;
            skid_valid_n   = 1'b0;
          end
        end
        default: begin
          out_valid_n  = 1'b0;
          skid_valid_n = 1'b0;
        end
      endcase
    end
  end

  // Valid flags and the registered in_ready (mirror of the next skid_valid).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      out_valid  <= out_valid_n;
      skid_valid <= skid_valid_n;
      in_ready   <= !skid_valid_n;
    end
  end

  pipe_data_reg #(
    .DATA_W    (DATA_W),
    .RESET_VAL (RESET_VAL)
  ) u_main_reg (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .clr (data_clr),
    .d   (main_d),
    .q   (out_data)
  );

  pipe_data_reg #(
    .DATA_W    (DATA_W),
    .RESET_VAL (RESET_VAL)
  ) u_skid_reg (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .clr (data_clr),
    .d   (in_data),
    .q   (skid_data)
  );

`ifdef PIPE_STAGE_REG_STALL_CNT_EN
  // Saturating count of downstream stall cycles; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 32'd0;
    end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
